// File: rtl/trace_emitter.sv
// trace_emitter: captures architecturally visible GRF writes from the
// writeback commit bundle, buffers them in a small FIFO and serializes each
// one as a 10-byte framed record on a byte-wide valid/ready stream:
//    SYNC, PC[31:24..7:0], {3'b000,A3}, WD[31:24..7:0]
module trace_emitter #(
   parameter int          DEPTH = 4,
   parameter logic [7:0]  SYNC  = 8'hA5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     commit_valid,
   input  logic                     commit_we,
   input  logic [31:0]              commit_pc,
   input  logic [4:0]               commit_a3,
   input  logic [31:0]              commit_wd,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [7:0]               drop_cnt,
   output logic                     busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int RW = 69;                    // {pc[31:0], a3[4:0], wd[31:0]}
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [3:0]    LAST_IDX = 4'd9;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // FIFO storage and bookkeeping
   logic [RW-1:0]  mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]  level_q,  level_d;
   logic [7:0]     drop_q,   drop_d;

   // serializer state
   state_t         state_q;
   logic [3:0]     idx_q;
   logic [RW-1:0]  rec_q;
   logic [7:0]     tx_data_q;
   logic           tx_valid_q;

   logic           qualify_s;
   logic           full_s;
   logic           push_s;
   logic           pop_s;
   logic [RW-1:0]  head_s;
   logic [RW-1:0]  new_rec_s;

   // Select one byte of a framed record by its position in the frame.
   function automatic logic [7:0] rec_byte(input logic [RW-1:0] rec,
                                           input logic [3:0]    idx);
      logic [7:0] b;
      case (idx)
         4'd0:    b = SYNC;
         4'd1:    b = rec[68:61];
         4'd2:    b = rec[60:53];
         4'd3:    b = rec[52:45];
         4'd4:    b = rec[44:37];
         4'd5:    b = {3'b000, rec[36:32]};
         4'd6:    b = rec[31:24];
         4'd7:    b = rec[23:16];
         4'd8:    b = rec[15:8];
         4'd9:    b = rec[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Commit qualification, push/pop/drop decisions and FIFO next-state.
   always_comb begin
      qualify_s = commit_valid && commit_we && (commit_a3 != 5'd0);
      // A pop in the same cycle never frees a slot for the push.
      full_s    = (level_q == DEPTH_L);
      push_s    = qualify_s && !full_s;
      pop_s     = (state_q == ST_IDLE) && (level_q != '0);
      head_s    = mem_q[rd_ptr_q];
      new_rec_s = {commit_pc, commit_a3, commit_wd};

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      if (qualify_s && full_s && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end else begin
         drop_d = drop_q;
      end
   end

   // FIFO pointers, occupancy and saturating drop counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         drop_q   <= 8'h00;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         drop_q   <= drop_d;
      end
   end

   // FIFO storage array; written at the tail on every accepted push.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_s) begin
         mem_q[wr_ptr_q] <= new_rec_s;
      end
   end

   // Serializer FSM: latch the head record, then walk its 10 bytes with
   // registered tx_valid/tx_data that only advance on an accepted byte.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= 4'd0;
         rec_q      <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pop_s) begin
                  rec_q      <= head_s;
                  idx_q      <= 4'd0;
                  tx_valid_q <= 1'b1;
                  tx_data_q  <= SYNC;
                  state_q    <= ST_SEND;
               end else begin
                  tx_valid_q <= 1'b0;
                  tx_data_q  <= 8'h00;
               end
            end
            ST_SEND: begin
               if (tx_ready) begin
                  if (idx_q == LAST_IDX) begin
                     // Last byte taken: spend at least one cycle in IDLE.
                     idx_q      <= 4'd0;
                     tx_valid_q <= 1'b0;
                     tx_data_q  <= 8'h00;
                     state_q    <= ST_IDLE;
                  end else begin
                     idx_q     <= idx_q + 4'd1;
                     tx_data_q <= rec_byte(rec_q, idx_q + 4'd1);
                  end
               end else begin
                  // Backpressure: hold the presented byte unchanged.
                  tx_valid_q <= 1'b1;
               end
            end
            default: begin
               idx_q      <= 4'd0;
               tx_valid_q <= 1'b0;
               tx_data_q  <= 8'h00;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_data    = tx_data_q;
   assign tx_valid   = tx_valid_q;
   assign fifo_level = level_q;
   assign drop_cnt   = drop_q;
   assign busy       = (state_q != ST_IDLE) || (level_q != '0);

endmodule

// File: tb/tb_trace_emitter.sv
// Scoreboard bench for trace_emitter: stimulus pushes the expected byte
// stream into a queue; a monitor pops and compares every accepted byte.
module tb_trace_emitter;

   logic        clk;
   logic        rst_n;
   logic        commit_valid;
   logic        commit_we;
   logic [31:0] commit_pc;
   logic [4:0]  commit_a3;
   logic [31:0] commit_wd;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [2:0]  fifo_level;
   logic [7:0]  drop_cnt;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] sb[$];

   trace_emitter #(.DEPTH(4), .SYNC(8'hA5)) dut (
      .clk          (clk),
      .reset        (rst_n),
      .commit_valid (commit_valid),
      .commit_we    (commit_we),
      .commit_pc    (commit_pc),
      .commit_a3    (commit_a3),
      .commit_wd    (commit_wd),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .fifo_level   (fifo_level),
      .drop_cnt     (drop_cnt),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Push the first n bytes of the expected frame for one record.
   task automatic push_rec(input logic [31:0] pc, input logic [4:0] a3,
                           input logic [31:0] wd, input int n);
      logic [7:0] f[10];
      f[0] = 8'hA5;
      f[1] = pc[31:24]; f[2] = pc[23:16]; f[3] = pc[15:8]; f[4] = pc[7:0];
      f[5] = {3'b000, a3};
      f[6] = wd[31:24]; f[7] = wd[23:16]; f[8] = wd[15:8]; f[9] = wd[7:0];
      for (int i = 0; i < n; i++) sb.push_back(f[i]);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic commit(input logic v, input logic we, input logic [31:0] pc,
                         input logic [4:0] a3, input logic [31:0] wd);
      commit_valid = v;
      commit_we    = we;
      commit_pc    = pc;
      commit_a3    = a3;
      commit_wd    = wd;
      step();
      commit_valid = 1'b0;
   endtask

   task automatic drain(input string nm, input int maxc);
      int c;
      c = 0;
      while (((sb.size() != 0) || busy) && (c < maxc)) begin
         step();
         c++;
      end
      check({nm, "_sb_empty"}, sb.size(), 0);
      check({nm, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   // Monitor: every byte accepted at the coming edge must match the queue head.
   always @(negedge clk) begin
      if (rst_n && tx_valid && tx_ready) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_byte: got %h expected none", tx_data);
         end else begin
            logic [7:0] e;
            e = sb.pop_front();
            if (tx_data !== e) begin
               n_fail++;
               $display("FAIL stream_byte: got %h expected %h", tx_data, e);
            end
         end
      end
   end

   initial begin
      int found;
      rst_n = 1'b0;
      commit_valid = 1'b0; commit_we = 1'b0;
      commit_pc = 32'h0; commit_a3 = 5'd0; commit_wd = 32'h0;
      tx_ready = 1'b0;
      step(); step();
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data}, 32'h00);
      check("rst_level", {29'd0, fifo_level}, 32'd0);
      check("rst_drop", {24'd0, drop_cnt}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      step();

      // 1: single commit, latency and frame contents
      tx_ready = 1'b1;
      push_rec(32'h0000_3000, 5'd8, 32'hDEAD_BEEF, 10);
      commit(1'b1, 1'b1, 32'h0000_3000, 5'd8, 32'hDEAD_BEEF);
      check("t1_valid_before_pop", {31'd0, tx_valid}, 32'd0);
      check("t1_level_after_push", {29'd0, fifo_level}, 32'd1);
      step();
      check("t1_valid_after_pop", {31'd0, tx_valid}, 32'd1);
      check("t1_first_byte", {24'd0, tx_data}, 32'hA5);
      check("t1_level_after_pop", {29'd0, fifo_level}, 32'd0);
      drain("t1", 30);
      check("t1_valid_end", {31'd0, tx_valid}, 32'd0);

      // 2: filtered commits produce nothing
      commit(1'b1, 1'b1, 32'h0000_4000, 5'd0, 32'h1111_1111);
      commit(1'b1, 1'b0, 32'h0000_4004, 5'd5, 32'h2222_2222);
      commit(1'b0, 1'b1, 32'h0000_4008, 5'd5, 32'h3333_3333);
      check("t2_level", {29'd0, fifo_level}, 32'd0);
      repeat (3) step();
      check("t2_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("t2_drop", {24'd0, drop_cnt}, 32'd0);
      check("t2_busy", {31'd0, busy}, 32'd0);

      // 3: backpressure at byte 3
      push_rec(32'h0000_3000, 5'd8, 32'hDEAD_BEEF, 10);
      commit(1'b1, 1'b1, 32'h0000_3000, 5'd8, 32'hDEAD_BEEF);
      found = 0;
      for (int i = 0; i < 20; i++) begin
         if (tx_valid && (tx_data == 8'h30)) begin
            found = 1;
            break;
         end
         step();
      end
      check("t3_reached_byte3", found, 1);
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t3_hold_valid", {31'd0, tx_valid}, 32'd1);
         check("t3_hold_data", {24'd0, tx_data}, 32'h30);
      end
      tx_ready = 1'b1;
      step();
      check("t3_resume_byte4", {24'd0, tx_data}, 32'h00);
      drain("t3", 30);

      // 4: overflow with 6 back-to-back commits under backpressure
      tx_ready = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         if (k <= 5) push_rec(32'h1000_0000 + 32'(k * 4), 5'(k), 32'hC0DE_0000 + 32'(k), 10);
         commit(1'b1, 1'b1, 32'h1000_0000 + 32'(k * 4), 5'(k), 32'hC0DE_0000 + 32'(k));
      end
      check("t4_level_full", {29'd0, fifo_level}, 32'd4);
      check("t4_drop_one", {24'd0, drop_cnt}, 32'd1);
      tx_ready = 1'b1;
      drain("t4", 100);
      check("t4_level_empty", {29'd0, fifo_level}, 32'd0);

      // 5: drop counter saturation
      tx_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         push_rec(32'h2000_0010, 5'd31, 32'h0BAD_F00D, 10);
         commit(1'b1, 1'b1, 32'h2000_0010, 5'd31, 32'h0BAD_F00D);
      end
      check("t5_level_full", {29'd0, fifo_level}, 32'd4);
      check("t5_drop_start", {24'd0, drop_cnt}, 32'd1);
      for (int k = 0; k < 253; k++) commit(1'b1, 1'b1, 32'h2000_0020, 5'd3, 32'h5);
      check("t5_drop_fe", {24'd0, drop_cnt}, 32'hFE);
      commit(1'b1, 1'b1, 32'h2000_0020, 5'd3, 32'h5);
      check("t5_drop_ff", {24'd0, drop_cnt}, 32'hFF);
      for (int k = 0; k < 46; k++) commit(1'b1, 1'b1, 32'h2000_0020, 5'd3, 32'h5);
      check("t5_drop_nowrap", {24'd0, drop_cnt}, 32'hFF);
      tx_ready = 1'b1;
      drain("t5", 100);
      check("t5_drop_after", {24'd0, drop_cnt}, 32'hFF);

      // 6: reset in the middle of byte 6 with 2 records queued
      push_rec(32'h3000_0100, 5'd9, 32'h1234_5678, 6);
      commit(1'b1, 1'b1, 32'h3000_0100, 5'd9, 32'h1234_5678);
      commit(1'b1, 1'b1, 32'h3000_0104, 5'd10, 32'h9ABC_DEF0);
      commit(1'b1, 1'b1, 32'h3000_0108, 5'd11, 32'h0F0F_0F0F);
      found = 0;
      for (int i = 0; i < 20; i++) begin
         if (sb.size() == 0) begin
            found = 1;
            break;
         end
         step();
      end
      check("t6_reached_byte6", found, 1);
      check("t6_byte6", {24'd0, tx_data}, 32'h12);
      check("t6_level_queued", {29'd0, fifo_level}, 32'd2);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", {31'd0, tx_valid}, 32'd0);
      check("t6_rst_level", {29'd0, fifo_level}, 32'd0);
      check("t6_rst_drop", {24'd0, drop_cnt}, 32'd0);
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      step(); step();
      rst_n = 1'b1;
      step();
      check("t6_idle_after_rst", {31'd0, tx_valid}, 32'd0);
      push_rec(32'h4000_0000, 5'd1, 32'hFEED_FACE, 10);
      commit(1'b1, 1'b1, 32'h4000_0000, 5'd1, 32'hFEED_FACE);
      step();
      check("t6_new_sync", {24'd0, tx_data}, 32'hA5);
      drain("t6", 30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
